// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory router: FSM states, access
// sizes, RISC-V fault causes and timer register offsets.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [3:0] CAUSE_LD_MIS = 4'd4;
  localparam logic [3:0] CAUSE_LD_FLT = 4'd5;
  localparam logic [3:0] CAUSE_ST_MIS = 4'd6;
  localparam logic [3:0] CAUSE_ST_FLT = 4'd7;

  // Word offsets inside the 32 KiB timer window.
  localparam logic [14:0] TMR_CMP_LO  = 15'h0000;
  localparam logic [14:0] TMR_CMP_HI  = 15'h0004;
  localparam logic [14:0] TMR_TIME_LO = 15'h7FF8;
  localparam logic [14:0] TMR_TIME_HI = 15'h7FFC;

  function automatic logic [31:0] merge_be(input logic [31:0] cur,
                                           input logic [31:0] nw,
                                           input logic [3:0]  be);
    for (int unsigned b = 0; b < 4; b++)
      merge_be[8*b +: 8] = be[b] ? nw[8*b +: 8] : cur[8*b +: 8];
  endfunction

endpackage

// File: rtl/dmem_router_lane_align.sv
// Combinational lane handling: store byte enables / lane replication /
// misalignment, and load shift plus sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic        misalign,
  input  logic [1:0]  ld_off,
  input  logic [2:0]  ld_size,
  input  logic [31:0] rdata,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  // size 2'b11 falls into the word arm
  always_comb begin
    be        = 4'hF;
    wdata_rep = wdata;
    misalign  = 1'b0;
    case (size[1:0])
      SZ_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        misalign  = off[0];
      end
      default: misalign = (off != 2'b00);
    endcase
  end

  always_comb begin
    shifted = rdata >> {ld_off, 3'b000};
    case (ld_size[1:0])
      SZ_B: rdata_ext = ld_size[2] ? {24'h0, shifted[7:0]}
                                   : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H: rdata_ext = ld_size[2] ? {16'h0, shifted[15:0]}
                                   : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_router.sv
// Data-memory router: decodes one CPU load/store against NUM_CH regions and runs
// a req/ack handshake on the winning channel. Optional timer under MTIMER_EN.
module dmem_router
  import dmem_pkg::*;
#(
  parameter int unsigned          NUM_CH     = 4,
  parameter logic [NUM_CH*32-1:0] CH_BASE    = {32'h8000_0000, 32'h2100_0000,
                                                32'h2000_0000, 32'h0000_0000},
  parameter logic [NUM_CH*32-1:0] CH_MASK    = {32'hFE00_0000, 32'hFFFF_0000,
                                                32'hFFFF_0000, 32'hFFFF_0000},
  parameter int unsigned          TIMEOUT    = 1023,
  parameter logic [31:0]          TIMER_BASE = 32'h2000_4000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [31:0]          cpu_addr,
  input  logic [31:0]          cpu_wdata,
  input  logic [2:0]           cpu_size,
  output logic                 cpu_done,
  output logic [31:0]          cpu_rdata,
  output logic                 cpu_fault,
  output logic [3:0]           cpu_cause,
  output logic [NUM_CH-1:0]    ch_req,
  output logic                 ch_we,
  output logic [31:0]          ch_addr,
  output logic [3:0]           ch_be,
  output logic [31:0]          ch_wdata,
  input  logic [NUM_CH-1:0]    ch_ack,
  input  logic [NUM_CH*32-1:0] ch_rdata,
  output logic                 timer_irq
);

  localparam int unsigned SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t            state;
  logic [SEL_W-1:0]  sel;
  logic [31:0]       cnt;
  logic              we_q;
  logic [1:0]        off_q;
  logic [2:0]        size_q;

  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic              misalign;
  logic [1:0]        ld_off;
  logic [2:0]        ld_size;
  logic [31:0]       ld_rdata;
  logic [31:0]       rdata_ext;

  logic              hit;
  logic [SEL_W-1:0]  hit_idx;
  logic              timer_hit;
  logic [31:0]       timer_rd;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!hit && ((cpu_addr & CH_MASK[32*i +: 32]) == CH_BASE[32*i +: 32])) begin
        hit     = 1'b1;
        hit_idx = SEL_W'(i);
      end
    end
  end

  // One extender serves timer reads (IDLE, live CPU fields) and channel reads
  // (ACCESS, fields captured at request time).
  assign ld_off   = (state == IDLE) ? cpu_addr[1:0] : off_q;
  assign ld_size  = (state == IDLE) ? cpu_size : size_q;
  assign ld_rdata = (state == IDLE) ? timer_rd : ch_rdata[{sel, 5'b00000} +: 32];

  dmem_lane_align u_align (
    .off       (cpu_addr[1:0]),
    .size      (cpu_size),
    .wdata     (cpu_wdata),
    .be        (be),
    .wdata_rep (wdata_rep),
    .misalign  (misalign),
    .ld_off    (ld_off),
    .ld_size   (ld_size),
    .rdata     (ld_rdata),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      cnt       <= '0;
      we_q      <= 1'b0;
      off_q     <= '0;
      size_q    <= '0;
      cpu_done  <= 1'b0;
      cpu_rdata <= '0;
      cpu_fault <= 1'b0;
      cpu_cause <= '0;
      ch_req    <= '0;
      ch_we     <= 1'b0;
      ch_addr   <= '0;
      ch_be     <= '0;
      ch_wdata  <= '0;
    end else begin
      cpu_done <= 1'b0;
      case (state)
        IDLE: begin
          cnt       <= '0;
          cpu_rdata <= '0;
          cpu_fault <= 1'b0;
          cpu_cause <= '0;
          if (cpu_req) begin
            we_q   <= cpu_we;
            off_q  <= cpu_addr[1:0];
            size_q <= cpu_size;
            if (misalign) begin
              state     <= RESP;
              cpu_done  <= 1'b1;
              cpu_fault <= 1'b1;
              cpu_cause <= cpu_we ? CAUSE_ST_MIS : CAUSE_LD_MIS;
            end else if (timer_hit) begin
              state     <= RESP;
              cpu_done  <= 1'b1;
              cpu_rdata <= cpu_we ? '0 : rdata_ext;
            end else if (hit) begin
              state    <= ACCESS;
              sel      <= hit_idx;
              ch_req   <= NUM_CH'(1) << hit_idx;
              ch_we    <= cpu_we;
              ch_addr  <= {cpu_addr[31:2], 2'b00};
              ch_be    <= be;
              ch_wdata <= wdata_rep;
            end else begin
              state     <= RESP;
              cpu_done  <= 1'b1;
              cpu_fault <= 1'b1;
              cpu_cause <= cpu_we ? CAUSE_ST_FLT : CAUSE_LD_FLT;
            end
          end
        end
        ACCESS: begin
          cnt <= cnt + 32'd1;
          if (ch_ack[sel]) begin
            state     <= RESP;
            ch_req    <= '0;
            cpu_done  <= 1'b1;
            cpu_rdata <= we_q ? '0 : rdata_ext;
          end else if (cnt + 32'd1 == TIMEOUT) begin
            state     <= RESP;
            ch_req    <= '0;
            cpu_done  <= 1'b1;
            cpu_fault <= 1'b1;
            cpu_cause <= we_q ? CAUSE_ST_FLT : CAUSE_LD_FLT;
          end
        end
        RESP: begin
          state     <= IDLE;
          cpu_rdata <= '0;
          cpu_fault <= 1'b0;
          cpu_cause <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MTIMER_EN
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] toff;
  logic [14:0] tword;
  logic        twr;

  assign toff      = cpu_addr - TIMER_BASE;
  assign tword     = toff[14:0] & 15'h7FFC;
  assign timer_hit = (toff[31:15] == '0);
  assign twr       = (state == IDLE) && cpu_req && cpu_we && !misalign && timer_hit;

  always_comb begin
    case (tword)
      TMR_CMP_LO:  timer_rd = mtimecmp[31:0];
      TMR_CMP_HI:  timer_rd = mtimecmp[63:32];
      TMR_TIME_LO: timer_rd = mtime[31:0];
      TMR_TIME_HI: timer_rd = mtime[63:32];
      default:     timer_rd = '0;
    endcase
  end

  // A CPU write to mtime takes precedence over the free-running increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime     <= '0;
      mtimecmp  <= '1;
      timer_irq <= 1'b0;
    end else begin
      mtime     <= mtime + 64'd1;
      timer_irq <= (mtime >= mtimecmp);
      if (twr) begin
        case (tword)
          TMR_CMP_LO:  mtimecmp[31:0]  <= merge_be(mtimecmp[31:0],  wdata_rep, be);
          TMR_CMP_HI:  mtimecmp[63:32] <= merge_be(mtimecmp[63:32], wdata_rep, be);
          TMR_TIME_LO: mtime[31:0]     <= merge_be(mtime[31:0],     wdata_rep, be);
          TMR_TIME_HI: mtime[63:32]    <= merge_be(mtime[63:32],    wdata_rep, be);
          default: ;
        endcase
      end
    end
  end
`else
  logic unused_timer_base;

  assign unused_timer_base = ^TIMER_BASE;
  assign timer_hit         = 1'b0;
  assign timer_rd          = '0;
  assign timer_irq         = 1'b0;
`endif

endmodule
